// File: rtl/iob_ext_mem_arbiter.sv
// Round-robin arbiter sharing one IOb slave port between N_MASTERS IOb masters.
// A grant covers one whole transaction: acceptance for writes, rvalid for reads.
module iob_ext_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic                            cke_i,
  input  logic [N_MASTERS-1:0]            m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i,
  output logic [N_MASTERS-1:0]            m_ready_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  output logic                            s_avalid_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [DATA_W/8-1:0]             s_wstrb_o,
  input  logic                            s_ready_i,
  input  logic [DATA_W-1:0]               s_rdata_i,
  input  logic                            s_rvalid_i,
  output logic [$clog2(N_MASTERS)-1:0]    grant_o
);

  localparam int G_W = $clog2(N_MASTERS);
  localparam int S_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, GRANT, RD_WAIT} state_t;

  state_t         state;
  logic [G_W-1:0] grant;
  logic [G_W-1:0] rr;
  logic [G_W-1:0] next_grant;
  logic [G_W-1:0] sel;
  logic           in_grant;

  function automatic logic [G_W-1:0] wrap_inc(input logic [G_W-1:0] g);
    if (int'(g) == N_MASTERS - 1) return '0;
    return g + 1'b1;
  endfunction

  // First requester found scanning rr, rr+1, ... modulo N_MASTERS.
  always_comb begin : rr_scan
    int   idx;
    logic found;
    idx        = 0;
    found      = 1'b0;
    next_grant = rr;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = int'(rr) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!found && m_avalid_i[idx]) begin
        found      = 1'b1;
        next_grant = G_W'(idx);
      end
    end
  end

  // Outside GRANT the slave request fields carry master 0's inputs.
  assign in_grant = (state == GRANT);
  assign sel      = in_grant ? grant : '0;

  assign s_avalid_o = in_grant & m_avalid_i[sel];
  assign s_addr_o   = m_addr_i[int'(sel)*ADDR_W +: ADDR_W];
  assign s_wdata_o  = m_wdata_i[int'(sel)*DATA_W +: DATA_W];
  assign s_wstrb_o  = m_wstrb_i[int'(sel)*S_W +: S_W];
  assign m_rdata_o  = s_rdata_i;
  assign grant_o    = grant;

  // Handshake: a request transfers on a cycle where avalid and ready are both
  // high; ready and rvalid are forwarded to the owner only, with no added delay.
  always_comb begin
    m_ready_o  = '0;
    m_rvalid_o = '0;
    if (in_grant) m_ready_o[grant] = s_ready_i;
    if (state == RD_WAIT) m_rvalid_o[grant] = s_rvalid_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
      grant <= '0;
      rr    <= '0;
    end else if (cke_i) begin
      case (state)
        IDLE: begin
          if (|m_avalid_i) begin
            grant <= next_grant;
            state <= GRANT;
          end
        end
        GRANT: begin
          // A request withdrawn before acceptance releases the port without
          // advancing rr.
          if (!s_avalid_o) begin
            state <= IDLE;
          end else if (s_ready_i) begin
            if (|s_wstrb_o) begin
              state <= IDLE;
              rr    <= wrap_inc(grant);
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (s_rvalid_i) begin
            state <= IDLE;
            rr    <= wrap_inc(grant);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/iob_ext_mem_arbiter.md
# iob_ext_mem_arbiter

Round-robin arbiter that shares one IOb native slave port between `N_MASTERS` IOb masters. Its first use is in the SoC, where it merges the CPU instruction and data external-memory buses into the single port of the external DDR/AXI memory controller. A grant is held for one complete transaction: acceptance for writes, read data return for reads. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `N_MASTERS`, 2: number of requesting masters, legal range 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; the strobe width is `DATA_W/8`.

Ports:
- `clk_i` in 1: system clock.
- `arst_i` in 1: reset, asynchronous and active-high.
- `cke_i` in 1: clock enable. When low, all state holds.
- `m_avalid_i` in N_MASTERS: per-master request valid.
- `m_addr_i` in N_MASTERS*ADDR_W: per-master address. Master k occupies bits [k*ADDR_W +: ADDR_W].
- `m_wdata_i` in N_MASTERS*DATA_W: per-master write data.
- `m_wstrb_i` in N_MASTERS*DATA_W/8: per-master byte strobes. Nonzero means write, zero means read.
- `m_ready_o` out N_MASTERS: per-master acceptance.
- `m_rdata_o` out DATA_W: read data, shared by all masters.
- `m_rvalid_o` out N_MASTERS: per-master read-data valid.
- `s_avalid_o`, `s_addr_o`, `s_wdata_o`, `s_wstrb_o` out 1/ADDR_W/DATA_W/DATA_W/8: request to the slave.
- `s_ready_i`, `s_rdata_i`, `s_rvalid_i` in 1/DATA_W/1: response from the slave.
- `grant_o` out $clog2(N_MASTERS): index of the current owner. Debug/observability only.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner's request is forwarded to the slave.
  - RD_WAIT: read accepted, waiting for `s_rvalid_i`.
- Round-robin pointer `rr`: the master with highest priority next. Reset value 0.
- IDLE:
  - If any `m_avalid_i` is set, register as `grant` the first requester found scanning `rr`, `rr+1`, … modulo N_MASTERS, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `s_avalid_o/addr/wdata/wstrb` equal the owner's inputs.
  - `m_ready_o[grant]` equals `s_ready_i`. All other `m_ready_o` bits are 0.
  - On `s_avalid_o & s_ready_i` with nonzero wstrb (write): go to IDLE and set `rr = grant+1` (mod N_MASTERS).
  - On `s_avalid_o & s_ready_i` with zero wstrb (read): go to RD_WAIT.
  - If the owner drops avalid before ready (protocol violation): go to IDLE with no `rr` update.
- RD_WAIT:
  - `s_avalid_o` is 0.
  - On `s_rvalid_i`: `m_rvalid_o[grant]` is 1 for that cycle, then go to IDLE and set `rr = grant+1`.
- `m_rdata_o` is always `s_rdata_i`. `m_rvalid_o` has at most one bit set.
- A `s_rvalid_i` arriving outside RD_WAIT is ignored and never forwarded.
- Non-owner requests are held pending with `m_ready_o=0`. Masters must keep their request stable until ready.
- Reset mid-transaction: return to IDLE immediately, set `rr=0`, drop the slave request. A slave response still in flight after reset is discarded under the outside-RD_WAIT rule.

## Timing
- Reset values: state IDLE, `grant_o=0`, `s_avalid_o=0`, `m_ready_o=0`, `m_rvalid_o=0`.
- `s_addr_o`, `s_wdata_o`, `s_wstrb_o` and `m_rdata_o` follow their muxed inputs. Outside GRANT they carry master 0's fields, or `s_rdata_i` for `m_rdata_o`.
- Arbitration latency: a request first seen in IDLE at cycle t drives `s_avalid_o` at t+1.
- Ready and rvalid pass combinationally from slave to master, with zero added latency.
- Write, slave ready immediately: request at t, accepted at t+1. The next grant is registered at t+2, so that slave request appears at t+3.
- Read: rvalid is forwarded in the same cycle it arrives. The FSM is back in IDLE the following cycle.
- Peak throughput: one transaction per 2 cycles, plus slave latency.
- Simultaneous requests are resolved by `rr` only. A master never waits more than N_MASTERS-1 transactions.
- When `cke_i` is low, FSM, `grant` and `rr` freeze. Combinational forwarding still reflects the frozen state.

## Test plan
- Reset, no requests: all outputs zero and `grant_o=0`. `s_rvalid_i=1` injected in IDLE gives `m_rvalid_o=0`.
- Master 1 alone writes addr 0x100, data 0xDEADBEEF, wstrb 0xF, with `s_ready_i` tied high: `s_avalid_o` high one cycle later with matching fields, `m_ready_o=2'b10` in the same cycle, IDLE after.
- Master 0 read with `s_ready_i` at the first slave cycle and `s_rvalid_i` 3 cycles later carrying 0x12345678: `m_rvalid_o=2'b01` in exactly that cycle with `m_rdata_o=0x12345678`, and no `m_rvalid_o` on master 1.
- Both masters request writes continuously for 8 transactions: grants alternate 0,1,0,1,… and each master completes 4.
- N_MASTERS=4, masters 0, 2 and 3 requesting with `rr=3` after a grant to master 2: order 3,0,2.
- `arst_i` pulsed in RD_WAIT, then a late `s_rvalid_i`: outputs go to zero immediately, the late rvalid is not forwarded, and the next request is granted normally.
